// File: rtl/mips32_pkg.sv
// Shared opcodes, instruction classes and field helpers for the five-stage MIPS32 core.
package mips32_pkg;

  localparam logic [5:0] OpAdd   = 6'b000000;
  localparam logic [5:0] OpSub   = 6'b000001;
  localparam logic [5:0] OpAnd   = 6'b000010;
  localparam logic [5:0] OpOr    = 6'b000011;
  localparam logic [5:0] OpSlt   = 6'b000100;
  localparam logic [5:0] OpMul   = 6'b000101;
  localparam logic [5:0] OpLw    = 6'b001000;
  localparam logic [5:0] OpSw    = 6'b001001;
  localparam logic [5:0] OpAddi  = 6'b001010;
  localparam logic [5:0] OpSubi  = 6'b001011;
  localparam logic [5:0] OpSlti  = 6'b001100;
  localparam logic [5:0] OpBneqz = 6'b001101;
  localparam logic [5:0] OpBeqz  = 6'b001110;
  localparam logic [5:0] OpHlt   = 6'b111111;

  localparam logic [31:0] Nop = 32'h0000_0000;

  typedef enum logic [2:0] {
    ClsNop, ClsRrAlu, ClsRmAlu, ClsLoad, ClsStore, ClsBranch, ClsHalt
  } instr_cls_e;

  typedef enum logic [2:0] {
    AluAdd, AluSub, AluAnd, AluOr, AluSlt, AluMul
  } alu_op_e;

  function automatic logic [5:0] f_opcode(input logic [31:0] ir);
    return ir[31:26];
  endfunction

  function automatic logic [4:0] f_rs(input logic [31:0] ir);
    return ir[25:21];
  endfunction

  function automatic logic [4:0] f_rt(input logic [31:0] ir);
    return ir[20:16];
  endfunction

  function automatic logic [4:0] f_rd(input logic [31:0] ir);
    return ir[15:11];
  endfunction

  function automatic logic [31:0] f_imm(input logic [31:0] ir);
    return {{16{ir[15]}}, ir[15:0]};
  endfunction

  function automatic instr_cls_e decode_cls(input logic [5:0] op);
    case (op)
      OpAdd, OpSub, OpAnd, OpOr, OpSlt, OpMul: return ClsRrAlu;
      OpAddi, OpSubi, OpSlti:                  return ClsRmAlu;
      OpLw:                                    return ClsLoad;
      OpSw:                                    return ClsStore;
      OpBneqz, OpBeqz:                         return ClsBranch;
      OpHlt:                                   return ClsHalt;
      default:                                 return ClsNop;
    endcase
  endfunction

  // Loads, stores and branch targets all reduce to an add.
  function automatic alu_op_e decode_alu(input logic [5:0] op);
    case (op)
      OpSub, OpSubi: return AluSub;
      OpAnd:         return AluAnd;
      OpOr:          return AluOr;
      OpSlt, OpSlti: return AluSlt;
      OpMul:         return AluMul;
      default:       return AluAdd;
    endcase
  endfunction

endpackage

// File: rtl/mips32_alu.sv
// Combinational ALU for the EX stage.
module mips32_alu
  import mips32_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  alu_op_e          op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  output logic [XLEN-1:0]  y
);

  always_comb begin
    y = '0;
    case (op)
      AluAdd:  y = a + b;
      AluSub:  y = a - b;
      AluAnd:  y = a & b;
      AluOr:   y = a | b;
      AluSlt:  y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      AluMul:  y = a * b;
      default: y = a + b;
    endcase
  end

endmodule

// File: rtl/my_pipe_mips32.sv
// Five-stage in-order MIPS32 core with unified word-addressed memory; no forwarding or
// interlocks, taken branches squash the two younger instructions.
module my_pipe_mips32
  import mips32_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 1024,
  parameter int unsigned XLEN      = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            halted,
  output logic [XLEN-1:0] pc
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);

  logic [XLEN-1:0] Mem [MEM_DEPTH];
  logic [XLEN-1:0] gpr [32];

  logic [XLEN-1:0] pc_q;
  logic            halted_q, taken_q, hlt_seen_q;

  logic [XLEN-1:0] ifid_ir_q, ifid_npc_q;

  instr_cls_e      idex_cls_q;
  alu_op_e         idex_alu_q;
  logic            idex_zero_q;
  logic [4:0]      idex_dest_q;
  logic [XLEN-1:0] idex_a_q, idex_b_q, idex_imm_q, idex_npc_q;

  instr_cls_e      exmem_cls_q;
  logic [4:0]      exmem_dest_q;
  logic [XLEN-1:0] exmem_alu_q, exmem_b_q;

  instr_cls_e      memwb_cls_q;
  logic [4:0]      memwb_dest_q;
  logic [XLEN-1:0] memwb_alu_q, memwb_lmd_q;

  assign pc     = pc_q;
  assign halted = halted_q;

  // ID: the slot right behind a taken branch is decoded as a NOP.
  logic [XLEN-1:0] id_ir;
  logic [5:0]      id_op;
  instr_cls_e      id_cls;
  logic [4:0]      id_dest;
  logic            id_halt, stall_if;

  // EX
  logic [XLEN-1:0] ex_a, ex_b, ex_y;
  logic            take_branch;

  // MEM / WB
  logic [XLEN-1:0] fetch_word, mem_rdata, wb_data;
  logic            wb_we;

  always_comb begin
    id_ir   = taken_q ? Nop : ifid_ir_q;
    id_op   = f_opcode(id_ir);
    id_cls  = decode_cls(id_op);
    id_dest = (id_cls == ClsRrAlu) ? f_rd(id_ir) : f_rt(id_ir);

    ex_a = (idex_cls_q == ClsBranch) ? idex_npc_q : idex_a_q;
    ex_b = (idex_cls_q == ClsRrAlu) ? idex_b_q : idex_imm_q;
    take_branch = (idex_cls_q == ClsBranch) &&
                  (idex_zero_q ? (idex_a_q == '0) : (idex_a_q != '0));

    id_halt  = (id_cls == ClsHalt) && !take_branch;
    stall_if = id_halt || hlt_seen_q;

    fetch_word = Mem[pc_q[AW-1:0]];
    mem_rdata  = Mem[exmem_alu_q[AW-1:0]];

    wb_we   = !halted_q && (memwb_dest_q != 5'd0) &&
              (memwb_cls_q == ClsRrAlu || memwb_cls_q == ClsRmAlu || memwb_cls_q == ClsLoad);
    wb_data = (memwb_cls_q == ClsLoad) ? memwb_lmd_q : memwb_alu_q;
  end

  mips32_alu #(
    .XLEN (XLEN)
  ) u_alu (
    .op (idex_alu_q),
    .a  (ex_a),
    .b  (ex_b),
    .y  (ex_y)
  );

  // Pipeline registers are reset to a decoded NOP; everything freezes once halted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= '0;
      halted_q     <= 1'b0;
      taken_q      <= 1'b0;
      hlt_seen_q   <= 1'b0;
      ifid_ir_q    <= Nop;
      ifid_npc_q   <= '0;
      idex_cls_q   <= ClsRrAlu;
      idex_alu_q   <= AluAdd;
      idex_zero_q  <= 1'b0;
      idex_dest_q  <= '0;
      idex_a_q     <= '0;
      idex_b_q     <= '0;
      idex_imm_q   <= '0;
      idex_npc_q   <= '0;
      exmem_cls_q  <= ClsRrAlu;
      exmem_dest_q <= '0;
      exmem_alu_q  <= '0;
      exmem_b_q    <= '0;
      memwb_cls_q  <= ClsRrAlu;
      memwb_dest_q <= '0;
      memwb_alu_q  <= '0;
      memwb_lmd_q  <= '0;
      for (int i = 0; i < 32; i++) gpr[i] <= '0;
    end else if (!halted_q) begin
      // IF
      if (take_branch)    pc_q <= ex_y;
      else if (!stall_if) pc_q <= pc_q + 1'b1;
      ifid_ir_q  <= stall_if ? Nop : fetch_word;
      ifid_npc_q <= pc_q + 1'b1;
      taken_q    <= take_branch;
      if (id_halt) hlt_seen_q <= 1'b1;

      // ID
      if (take_branch) begin
        idex_cls_q  <= ClsNop;
        idex_alu_q  <= AluAdd;
        idex_zero_q <= 1'b0;
        idex_dest_q <= '0;
      end else begin
        idex_cls_q  <= id_cls;
        idex_alu_q  <= decode_alu(id_op);
        idex_zero_q <= (id_op == OpBeqz);
        idex_dest_q <= id_dest;
      end
      idex_a_q   <= gpr[f_rs(id_ir)];
      idex_b_q   <= gpr[f_rt(id_ir)];
      idex_imm_q <= f_imm(id_ir);
      idex_npc_q <= ifid_npc_q;

      // EX
      exmem_cls_q  <= idex_cls_q;
      exmem_dest_q <= idex_dest_q;
      exmem_alu_q  <= ex_y;
      exmem_b_q    <= idex_b_q;

      // MEM
      memwb_cls_q  <= exmem_cls_q;
      memwb_dest_q <= exmem_dest_q;
      memwb_alu_q  <= exmem_alu_q;
      memwb_lmd_q  <= mem_rdata;

      // WB
      if (wb_we) gpr[memwb_dest_q] <= wb_data;
      if (memwb_cls_q == ClsHalt) halted_q <= 1'b1;
    end
  end

  // Memory contents survive reset; they are loaded externally.
  always_ff @(posedge clk) begin
    if (rst_n && !halted_q && exmem_cls_q == ClsStore) begin
      Mem[exmem_alu_q[AW-1:0]] <= exmem_b_q;
    end
  end

endmodule

// File: tb/tb_my_pipe_mips32.sv
// Directed program bench for my_pipe_mips32: preloads Mem, runs to halt, checks state.
module tb_my_pipe_mips32;

  localparam logic [5:0] OAdd = 6'b000000, OSub = 6'b000001, OAnd = 6'b000010;
  localparam logic [5:0] OOr = 6'b000011, OSlt = 6'b000100, OMul = 6'b000101;
  localparam logic [5:0] OLw = 6'b001000, OSw = 6'b001001, OAddi = 6'b001010;
  localparam logic [5:0] OSubi = 6'b001011, OBnz = 6'b001101, OBeqz = 6'b001110;
  localparam logic [5:0] OHlt = 6'b111111, OBad = 6'b010000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        halted;
  logic [31:0] pc;

  int passes = 0;
  int total  = 0;

  my_pipe_mips32 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .halted (halted),
    .pc     (pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rr(logic [5:0] op, int rd, int rs, int rt);
    return {op, rs[4:0], rt[4:0], rd[4:0], 11'b0};
  endfunction

  function automatic logic [31:0] ri(logic [5:0] op, int rt, int rs, int imm);
    return {op, rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) dut.Mem[i] = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_to_halt(input string tag);
    int n = 0;
    while (!halted && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'b0, halted}, 32'd1);
  endtask

  initial begin
    // ALU chain, R0/NOP/unknown opcode, SW after HLT
    clear_mem();
    dut.Mem[0]  = ri(OAddi, 1, 0, 10);
    dut.Mem[1]  = ri(OAddi, 2, 0, 20);
    dut.Mem[2]  = ri(OSubi, 12, 0, 5);
    dut.Mem[5]  = rr(OAdd, 3, 1, 2);
    dut.Mem[9]  = rr(OSub, 4, 2, 1);
    dut.Mem[10] = rr(OMul, 5, 1, 2);
    dut.Mem[11] = rr(OSlt, 6, 1, 2);
    dut.Mem[12] = rr(OMul, 0, 1, 2);
    dut.Mem[13] = ri(OBad, 7, 1, 5);
    dut.Mem[14] = rr(OSlt, 15, 12, 1);
    dut.Mem[15] = rr(OAnd, 13, 1, 2);
    dut.Mem[16] = rr(OOr, 14, 1, 2);
    dut.Mem[17] = {OHlt, 26'b0};
    dut.Mem[18] = ri(OSw, 1, 0, 200);
    dut.Mem[200] = 32'hDEAD_BEEF;
    #1;
    chk("reset_pc", pc, 32'd0);
    chk("reset_halted", {31'b0, halted}, 32'd0);
    do_reset();
    chk("reset_ifid_nop", dut.ifid_ir_q, 32'h0);
    chk("reset_gpr5", dut.gpr[5], 32'd0);
    run_to_halt("alu_halt");
    chk("add_r3", dut.gpr[3], 32'd30);
    chk("sub_r4", dut.gpr[4], 32'd10);
    chk("mul_r5", dut.gpr[5], 32'd200);
    chk("slt_r6", dut.gpr[6], 32'd1);
    chk("r0_zero", dut.gpr[0], 32'd0);
    chk("unknown_r7", dut.gpr[7], 32'd0);
    chk("subi_r12", dut.gpr[12], 32'hFFFF_FFFB);
    chk("slt_signed_r15", dut.gpr[15], 32'd1);
    chk("and_r13", dut.gpr[13], 32'd0);
    chk("or_r14", dut.gpr[14], 32'd30);
    chk("halt_pc", pc, 32'd18);
    repeat (20) @(negedge clk);
    chk("halt_pc_frozen", pc, 32'd18);
    chk("sw_after_hlt", dut.Mem[200], 32'hDEAD_BEEF);

    // Load/store plus address wrap
    clear_mem();
    dut.Mem[0]   = ri(OAddi, 1, 0, 120);
    dut.Mem[4]   = ri(OLw, 2, 1, 0);
    dut.Mem[8]   = ri(OAddi, 2, 2, 45);
    dut.Mem[12]  = ri(OSw, 2, 1, 1);
    dut.Mem[13]  = ri(OSw, 2, 0, -1);
    dut.Mem[14]  = {OHlt, 26'b0};
    dut.Mem[120] = 32'd85;
    do_reset();
    run_to_halt("ls_halt");
    chk("ls_r2", dut.gpr[2], 32'd130);
    chk("ls_mem121", dut.Mem[121], 32'd130);
    chk("ls_wrap1023", dut.Mem[1023], 32'd130);

    // Branch taken (R9=0) then fall-through (R9=5)
    clear_mem();
    dut.Mem[0]  = ri(OAddi, 8, 0, 7);
    dut.Mem[1]  = ri(OAddi, 9, 0, 0);
    dut.Mem[5]  = ri(OBeqz, 0, 9, 4);
    dut.Mem[6]  = ri(OAddi, 8, 8, 1);
    dut.Mem[7]  = ri(OAddi, 18, 0, 2);
    dut.Mem[8]  = ri(OAddi, 19, 0, 3);
    dut.Mem[10] = ri(OAddi, 7, 0, 33);
    dut.Mem[11] = {OHlt, 26'b0};
    do_reset();
    run_to_halt("bt_halt");
    chk("bt_r8", dut.gpr[8], 32'd7);
    chk("bt_r18", dut.gpr[18], 32'd0);
    chk("bt_r19", dut.gpr[19], 32'd0);
    chk("bt_target_r7", dut.gpr[7], 32'd33);
    dut.Mem[1] = ri(OAddi, 9, 0, 5);
    do_reset();
    run_to_halt("bf_halt");
    chk("bf_r8", dut.gpr[8], 32'd8);
    chk("bf_r18", dut.gpr[18], 32'd2);
    chk("bf_r19", dut.gpr[19], 32'd3);
    chk("bf_r7", dut.gpr[7], 32'd33);

    // BNEQZ squashing a HLT and a SW
    clear_mem();
    dut.Mem[0] = ri(OAddi, 9, 0, 5);
    dut.Mem[4] = ri(OBnz, 0, 9, 3);
    dut.Mem[5] = {OHlt, 26'b0};
    dut.Mem[6] = ri(OSw, 9, 0, 300);
    dut.Mem[8] = ri(OAddi, 20, 0, 44);
    dut.Mem[9] = {OHlt, 26'b0};
    do_reset();
    run_to_halt("sq_halt");
    chk("sq_r20", dut.gpr[20], 32'd44);
    chk("sq_mem300", dut.Mem[300], 32'd0);
    chk("sq_pc", pc, 32'd10);

    // Reset in the middle of a counted loop, then rerun
    clear_mem();
    dut.Mem[0]  = ri(OAddi, 1, 0, 3);
    dut.Mem[1]  = ri(OAddi, 2, 0, 0);
    dut.Mem[4]  = ri(OAddi, 2, 2, 5);
    dut.Mem[5]  = ri(OSubi, 1, 1, 1);
    dut.Mem[9]  = ri(OBnz, 0, 1, -6);
    dut.Mem[10] = ri(OSw, 2, 0, 400);
    dut.Mem[11] = {OHlt, 26'b0};
    do_reset();
    repeat (14) @(negedge clk);
    chk("loop_running", {31'b0, halted}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midreset_pc", pc, 32'd0);
    chk("midreset_halted", {31'b0, halted}, 32'd0);
    chk("midreset_r2", dut.gpr[2], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_to_halt("loop_halt");
    chk("loop_r2", dut.gpr[2], 32'd15);
    chk("loop_r1", dut.gpr[1], 32'd0);
    chk("loop_mem400", dut.Mem[400], 32'd15);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
